// File: rtl/mem_march_tester_if.sv
// Host command, read response and self-test status bundle for mem_march_tester.
// The host (master) issues commands and BIST starts; the tester (slave) answers.
interface mem_march_tester_if #(
    parameter int ADDR_BITS = 4,
    parameter int DATA_BITS = 8
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_we;
    logic [ADDR_BITS-1:0] cmd_addr;
    logic [DATA_BITS-1:0] cmd_wdata;
    logic                 rd_valid;
    logic [DATA_BITS-1:0] rd_data;
    logic                 bist_start;
    logic                 bist_busy;
    logic                 bist_done;
    logic                 bist_pass;
    logic [ADDR_BITS-1:0] bist_fail_addr;

    modport master (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, bist_start,
        input  cmd_ready, rd_valid, rd_data, bist_busy, bist_done, bist_pass, bist_fail_addr
    );

    modport slave (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, bist_start,
        output cmd_ready, rd_valid, rd_data, bist_busy, bist_done, bist_pass, bist_fail_addr
    );
endinterface

// File: rtl/mem_march_tester.sv
// Flop-array memory with a host port and a built-in March C- style self-test.
// Optional macro MEM_TEST_FAULT_INJECT_EN adds fault_en, forcing bit 0 of FAULT_ADDR reads high.
module mem_march_tester #(
    parameter int ADDR_BITS  = 4,
    parameter int DATA_BITS  = 8,
    parameter int FAULT_ADDR = 5
) (
    input  logic                clk,
    input  logic                rst,
`ifdef MEM_TEST_FAULT_INJECT_EN
    input  logic                fault_en,
`endif
    mem_march_tester_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] W0   = 3'd1;
    localparam logic [2:0] R0W1 = 3'd2;
    localparam logic [2:0] R1W0 = 3'd3;
    localparam logic [2:0] R0   = 3'd4;
    localparam logic [2:0] DONE = 3'd5;

    logic [DATA_BITS-1:0] mem_q [DEPTH];

    logic [2:0]           state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 phase_q, phase_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [ADDR_BITS-1:0] failAddr_q, failAddr_d;
    logic                 rdValid_q, rdValid_d;
    logic [DATA_BITS-1:0] rdData_q, rdData_d;

    logic                 busy;
    logic                 hostAccept;
    logic                 memWe;
    logic [ADDR_BITS-1:0] memWaddr;
    logic [DATA_BITS-1:0] memWdata;
    logic [DATA_BITS-1:0] hostWord;
    logic [DATA_BITS-1:0] bistWord;

    function automatic logic [DATA_BITS-1:0] readWord(input logic [ADDR_BITS-1:0] a);
        logic [DATA_BITS-1:0] w;
        w = mem_q[a];
`ifdef MEM_TEST_FAULT_INJECT_EN
        if (fault_en && a == ADDR_BITS'(FAULT_ADDR)) begin
            w[0] = 1'b1;
        end
`endif
        return w;
    endfunction

    assign busy       = (state_q != IDLE) && (state_q != DONE);
    assign hostAccept = bus.cmd_valid && bus.cmd_ready;
    assign hostWord   = readWord(bus.cmd_addr);
    assign bistWord   = readWord(addr_q);

    assign bus.cmd_ready      = !busy && !bus.bist_start;
    assign bus.bist_busy      = busy;
    assign bus.bist_done      = done_q;
    assign bus.bist_pass      = pass_q;
    assign bus.bist_fail_addr = failAddr_q;
    assign bus.rd_valid       = rdValid_q;
    assign bus.rd_data        = rdData_q;

    // March sequencer: compare cycles may divert to DONE on the first mismatch
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        phase_d    = phase_q;
        done_d     = done_q;
        pass_d     = pass_q;
        failAddr_d = failAddr_q;
        memWe      = 1'b0;
        memWaddr   = addr_q;
        memWdata   = '0;
        rdValid_d  = 1'b0;
        rdData_d   = rdData_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.bist_start) begin
                    state_d    = W0;
                    addr_d     = '0;
                    phase_d    = 1'b0;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    failAddr_d = '0;
                end else if (hostAccept) begin
                    if (bus.cmd_we) begin
                        memWe    = 1'b1;
                        memWaddr = bus.cmd_addr;
                        memWdata = bus.cmd_wdata;
                    end else begin
                        rdValid_d = 1'b1;
                        rdData_d  = hostWord;
                    end
                end
            end
            W0: begin
                memWe = 1'b1;
                if (addr_q == LAST_ADDR) begin
                    state_d = R0W1;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            R0W1: begin
                if (!phase_q) begin
                    if (bistWord != '0) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        failAddr_d = addr_q;
                    end else begin
                        phase_d = 1'b1;
                    end
                end else begin
                    memWe    = 1'b1;
                    memWdata = '1;
                    phase_d  = 1'b0;
                    if (addr_q == LAST_ADDR) begin
                        state_d = R1W0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            R1W0: begin
                if (!phase_q) begin
                    if (bistWord != '1) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        failAddr_d = addr_q;
                    end else begin
                        phase_d = 1'b1;
                    end
                end else begin
                    memWe   = 1'b1;
                    phase_d = 1'b0;
                    if (addr_q == '0) begin
                        state_d = R0;
                    end else begin
                        addr_d = addr_q - 1'b1;
                    end
                end
            end
            R0: begin
                if (bistWord != '0) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    failAddr_d = addr_q;
                end else if (addr_q == LAST_ADDR) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            phase_q    <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            failAddr_q <= '0;
            rdValid_q  <= 1'b0;
            rdData_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            phase_q    <= phase_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            failAddr_q <= failAddr_d;
            rdValid_q  <= rdValid_d;
            rdData_q   <= rdData_d;
        end
    end

    // Array contents survive reset so an aborted test leaves its partial pattern
    always_ff @(posedge clk) begin
        if (memWe && !rst) begin
            mem_q[memWaddr] <= memWdata;
        end
    end
endmodule

// File: tb/tb_mem_march_tester.sv
// Self-checking bench for mem_march_tester: host read scoreboard plus BIST timing checks.
// Build with MEM_TEST_FAULT_INJECT_EN defined to also exercise the fault-injection run.
module tb_mem_march_tester;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int DEPTH = 2 ** AW;

    logic clk;
    logic rst;
    logic faultEn;

    int checkCount;
    int failCount;
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] expQ [$];

    mem_march_tester_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) bus ();

    mem_march_tester #(.ADDR_BITS(AW), .DATA_BITS(DW), .FAULT_ADDR(5)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef MEM_TEST_FAULT_INJECT_EN
        .fault_en (faultEn),
`endif
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%0h required=0x%0h", tag, observed, expected);
        end
    endtask

    // Read responses are popped from the scoreboard as they appear
    always @(negedge clk) begin
        if (!rst && bus.rd_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("rdUnexpected", 32'd1, 32'd0);
            end else begin
                checkOutput("rdData", 32'(bus.rd_data), 32'(expQ.pop_front()));
            end
        end
    end

    task automatic idleInputs();
        bus.cmd_valid  = 1'b0;
        bus.cmd_we     = 1'b0;
        bus.cmd_addr   = '0;
        bus.cmd_wdata  = '0;
        bus.bist_start = 1'b0;
    endtask

    task automatic applyStimulus(input logic valid, input logic we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic start);
        bus.cmd_valid  = valid;
        bus.cmd_we     = we;
        bus.cmd_addr   = addr;
        bus.cmd_wdata  = wdata;
        bus.bist_start = start;
        if (valid && !start) begin
            if (we) model[addr] = wdata;
            else expQ.push_back(model[addr]);
        end
        @(posedge clk);
        #1;
        idleInputs();
    endtask

    task automatic runBist(input int expCycles, input logic expPass, input logic [AW-1:0] expFail,
                           input int restartAt, input string tag);
        int cycles;
        cycles = 0;
        checkOutput({tag, "DoneCleared"}, 32'(bus.bist_done), 32'd0);
        while (bus.bist_busy === 1'b1 && cycles < 500) begin
            cycles++;
            if (cycles == 10) checkOutput({tag, "ReadyBusy"}, 32'(bus.cmd_ready), 32'd0);
            bus.bist_start = (cycles == restartAt);
            @(posedge clk);
            #1;
            bus.bist_start = 1'b0;
        end
        checkOutput({tag, "Cycles"}, 32'(cycles), 32'(expCycles));
        checkOutput({tag, "Done"}, 32'(bus.bist_done), 32'd1);
        checkOutput({tag, "Pass"}, 32'(bus.bist_pass), 32'(expPass));
        checkOutput({tag, "FailAddr"}, 32'(bus.bist_fail_addr), 32'(expFail));
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        faultEn    = 1'b0;
        idleInputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstRdValid", 32'(bus.rd_valid), 32'd0);
        checkOutput("rstRdData", 32'(bus.rd_data), 32'd0);
        checkOutput("rstBusy", 32'(bus.bist_busy), 32'd0);
        checkOutput("rstDone", 32'(bus.bist_done), 32'd0);
        checkOutput("rstPass", 32'(bus.bist_pass), 32'd0);
        checkOutput("rstFailAddr", 32'(bus.bist_fail_addr), 32'd0);
        checkOutput("rstReady", 32'(bus.cmd_ready), 32'd1);
        rst = 1'b0;

        applyStimulus(1'b1, 1'b1, 4'd3, 8'hA5, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd3, 8'h00, 1'b0);
        checkOutput("rdValidPulse", 32'(bus.rd_valid), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("rdValidLow", 32'(bus.rd_valid), 32'd0);
        checkOutput("rdDataHold", 32'(bus.rd_data), 32'hA5);

        applyStimulus(1'b1, 1'b1, 4'd7, 8'h3C, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd7, 8'h00, 1'b0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, AW'($urandom_range(0, DEPTH - 1)), DW'($urandom), 1'b0);
            applyStimulus(1'b1, 1'b0, AW'($urandom_range(0, DEPTH - 1)), 8'h00, 1'b0);
        end
        @(posedge clk);
        #1;

        // Start and write together: start wins, the write is dropped
        bus.bist_start = 1'b1;
        bus.cmd_valid  = 1'b1;
        bus.cmd_we     = 1'b1;
        bus.cmd_addr   = 4'd2;
        bus.cmd_wdata  = 8'hFF;
        #1;
        checkOutput("startBlocksReady", 32'(bus.cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        idleInputs();
        checkOutput("busyAfterStart", 32'(bus.bist_busy), 32'd1);
        runBist(6 * DEPTH, 1'b1, '0, 30, "bist1");
        for (int a = 0; a < DEPTH; a++) model[a] = '0;
        for (int a = 0; a < DEPTH; a++) applyStimulus(1'b1, 1'b0, AW'(a), 8'h00, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("doneHolds", 32'(bus.bist_done), 32'd1);

        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
        repeat (39) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abortBusy", 32'(bus.bist_busy), 32'd0);
        checkOutput("abortDone", 32'(bus.bist_done), 32'd0);
        checkOutput("abortPass", 32'(bus.bist_pass), 32'd0);
        checkOutput("abortReady", 32'(bus.cmd_ready), 32'd1);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
        runBist(6 * DEPTH, 1'b1, '0, 0, "bist2");

`ifdef MEM_TEST_FAULT_INJECT_EN
        faultEn = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
        runBist(1 + DEPTH + 10, 1'b0, 4'd5, 0, "fault");
        faultEn = 1'b0;
`endif

        repeat (3) @(posedge clk);
        #1;
        checkOutput("sbEmpty", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end
endmodule

// File: doc/mem_march_tester.md
MEM_MARCH_TESTER -- requirements
Module: mem_march_tester

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 4: address width; DEPTH = 2**ADDR_BITS words.
REQ-002 SHALL have parameter DATA_BITS, default 8: word width.
REQ-003 SHALL have parameter FAULT_ADDR, default 5: injected-fault address; used only with MEM_TEST_FAULT_INJECT_EN.
REQ-004 SHALL have port clk  in  1: single clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1: reset, synchronous, active-high.
REQ-006 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_we in 1, cmd_addr in ADDR_BITS, cmd_wdata in DATA_BITS: host command channel.
REQ-007 SHALL have ports rd_valid out 1, rd_data out DATA_BITS: host read response.
REQ-008 SHALL have ports bist_start in 1, bist_busy out 1, bist_done out 1, bist_pass out 1, bist_fail_addr out ADDR_BITS: self-test control/status.

Function
REQ-009 SHALL contain a DEPTH x DATA_BITS flop array, written only on rising clk.
REQ-010 SHALL drive cmd_ready = !bist_busy && !bist_start (combinational); a command transfers when cmd_valid && cmd_ready.
REQ-011 Write accepted in cycle N SHALL update mem[cmd_addr] at end of N; read of that address accepted in N+1 returns new data.
REQ-012 Read accepted in cycle N SHALL give rd_valid=1 and rd_data=mem[cmd_addr] in N+1 only; rd_valid is a one-cycle pulse; rd_data holds its last value otherwise.
REQ-013 bist_start while idle SHALL start the test; cycle N start gives bist_busy=1 from N+1; bist_start while busy is ignored.
REQ-014 BIST FSM states SHALL be IDLE, W0, R0W1, R1W0, R0, DONE; DONE behaves as IDLE for bist_start and host commands.
REQ-015 W0: addresses 0..DEPTH-1 ascending, one cycle each, write all-zeros.
REQ-016 R0W1: ascending, two cycles per address: cycle A compare mem[a] to all-zeros, cycle B write all-ones.
REQ-017 R1W0: descending DEPTH-1..0, two cycles per address: compare to all-ones, then write all-zeros.
REQ-018 R0: ascending, one cycle each, compare to all-zeros; then DONE.
REQ-019 Compare SHALL use the combinational array read in the same cycle.
REQ-020 First mismatch SHALL go to DONE next cycle: bist_pass=0, bist_fail_addr=mismatching address, no further writes.
REQ-021 Passing run SHALL be busy for exactly 6*DEPTH cycles, then bist_done=1, bist_pass=1, bist_fail_addr=0, busy=0; array then all-zeros.
REQ-022 bist_done/bist_pass/bist_fail_addr SHALL hold until next accepted bist_start (which clears them) or reset.
REQ-023 Address counter SHALL not wrap: transitions occur at 0 and DEPTH-1 boundaries exactly.
REQ-024 bist_start and cmd_valid together while idle SHALL start BIST and not accept the command.

Reset
REQ-025 rst high at a rising edge SHALL force IDLE, rd_valid=0, rd_data=0, bist_busy=0, bist_done=0, bist_pass=0, bist_fail_addr=0; cmd_ready=1 following.
REQ-026 Array contents SHALL not be reset; reset during BIST aborts immediately, leaving partial contents.

Configuration
REQ-027 With MEM_TEST_FAULT_INJECT_EN defined, SHALL add input fault_en (1); while high, every read of FAULT_ADDR (host and BIST) returns bit 0 forced to 1.
REQ-028 Without MEM_TEST_FAULT_INJECT_EN, fault_en port and forcing logic SHALL be absent; reads are unmodified.

Verification
REQ-029 Reset, write 0xA5 to addr 3, read addr 3 -> next cycle rd_valid=1, rd_data=0xA5, rd_valid low after.
REQ-030 Write 0x3C addr 7 cycle N, read addr 7 cycle N+1 -> rd_data=0x3C at N+2.
REQ-031 Defaults, pulse bist_start -> busy exactly 96 cycles, then done=1, pass=1, fail_addr=0; host reads all addresses -> 0x00.
REQ-032 bist_start with cmd_valid write same cycle -> cmd_ready=0, no write; second bist_start mid-test -> no effect on 96-cycle duration.
REQ-033 MEM_TEST_FAULT_INJECT_EN, fault_en=1, bist_start cycle N -> mismatch at cycle N+1+16+10, done=1, pass=0, fail_addr=5.
REQ-034 rst asserted 40 cycles into BIST -> next cycle busy=0, done=0, pass=0, cmd_ready=1; new bist_start runs full 96 cycles and passes.
